// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - key event encoder and FIFO between key scanner and consumer
//
// Captures each key_flag strobe with its key_value mask, encodes the lowest
// pressed key index and a multi-key marker at write time, and queues the
// event for a valid/ready consumer.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key_flag   one-cycle strobe marking a new debounced key_value
//   key_value  debounced key mask, 1 = pressed
//   evt_valid  head entry available
//   evt_ready  consumer accepts head entry when evt_valid=1
//   evt_mask   raw mask of head entry (0 when empty)
//   evt_idx    lowest set bit index of head entry (0 when empty)
//   evt_multi  head entry had more than one key pressed (0 when empty)
//   evt_count  number of queued entries, 0..FIFO_DEPTH
//   overflow   sticky: an event was dropped because the FIFO was full
//   ovf_clr    synchronous clear of overflow
module key_event_fifo #(
  parameter int KEY_WIDTH  = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_flag,
  input  logic [KEY_WIDTH-1:0]  key_value,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [KEY_WIDTH-1:0]  evt_mask,
  output logic [IDX_WIDTH-1:0]  evt_idx,
  output logic                  evt_multi,
  output logic [ADDR_WIDTH:0]   evt_count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  typedef struct packed {
    logic [KEY_WIDTH-1:0] mask;
    logic [IDX_WIDTH-1:0] idx;
    logic                 multi;
  } entry_t;

  entry_t mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;

  entry_t wr_entry;
  entry_t head;
  logic   wr_req, rd_en, full, wr_en, drop;

  // Encode the incoming mask; the descending loop leaves the lowest set bit.
  always_comb begin
    wr_entry      = '0;
    wr_entry.mask = key_value;
    for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
      if (key_value[i]) wr_entry.idx = IDX_WIDTH'(i);
    end
    // Clearing the lowest set bit leaves something only if two or more were set.
    wr_entry.multi = |(key_value & (key_value - KEY_WIDTH'(1)));
  end

  always_comb begin
    wr_req = key_flag && (key_value != '0);
    rd_en  = (count_q != '0) && evt_ready;
    full   = (count_q == (ADDR_WIDTH+1)'(FIFO_DEPTH));
    // A same-cycle read frees the head slot, so a full FIFO still accepts.
    wr_en  = wr_req && (!full || rd_en);
    drop   = wr_req && full && !rd_en;

    wr_ptr_d = wr_en ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !rd_en) count_d = count_q + (ADDR_WIDTH+1)'(1);
    if (!wr_en && rd_en) count_d = count_q - (ADDR_WIDTH+1)'(1);

    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage holds no reset; empty-state outputs are masked below instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    evt_valid = (count_q != '0);
    evt_mask  = evt_valid ? head.mask  : '0;
    evt_idx   = evt_valid ? head.idx   : '0;
    evt_multi = evt_valid ? head.multi : 1'b0;
    evt_count = count_q;
    overflow  = ovf_q;
  end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Downstream consumer of the debounced key scanner.
- Captures each one-cycle key_flag strobe together with its active-high key_value mask.
- Encodes the event (lowest pressed key index, multi-key marker) and queues it in a small FIFO.
- Presents queued events to the application/control logic over a valid/ready handshake, so no key press is lost while the consumer is busy.

Parameters:
- KEY_WIDTH, 4: width of key_value mask; matches the scanner's key count.
- IDX_WIDTH, 2: width of the encoded key index; must satisfy 2^IDX_WIDTH >= KEY_WIDTH.
- FIFO_DEPTH, 8: number of event entries; power of two, >= 2.
- ADDR_WIDTH, 3: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_flag  in  1  one-cycle strobe from the scanner marking a new debounced key_value.
- key_value  in  KEY_WIDTH  debounced key mask, 1 = key pressed; sampled only when key_flag=1.
- evt_valid  out  1  head entry is available.
- evt_ready  in  1  consumer accepts the head entry when evt_valid=1.
- evt_mask  out  KEY_WIDTH  raw key mask of the head entry.
- evt_idx  out  IDX_WIDTH  index of the lowest set bit of the head entry's mask.
- evt_multi  out  1  head entry had more than one bit set.
- evt_count  out  ADDR_WIDTH+1  number of queued entries, 0..FIFO_DEPTH.
- overflow  out  1  sticky: at least one event was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=1, asynchronous): write/read pointers = 0; evt_count = 0; overflow = 0; evt_valid = 0; evt_mask = 0; evt_idx = 0; evt_multi = 0.
- Storage contents need no reset.
- Write request: key_flag=1 AND key_value != 0. If key_flag=1 and key_value=0, the event is ignored: no write, no overflow.
- Encoding happens at write time and is stored per entry:
  - idx = lowest set bit position of key_value.
  - multi = 1 when popcount(key_value) >= 2.
- Read: occurs when evt_valid=1 AND evt_ready=1. evt_ready while evt_valid=0 has no effect.
- evt_valid = (evt_count != 0). evt_mask, evt_idx and evt_multi always reflect the entry at the read pointer. They are forced to 0 when evt_count = 0.
- Latency: an event written on edge N is visible on evt_valid/evt_mask after edge N (cycle N+1) when the FIFO was empty. There is no combinational path from key_flag to the evt_* outputs.
- Ordering: strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- evt_count changes by:
  - +1 on write only;
  - -1 on read only;
  - 0 when write and read occur in the same cycle.
- Full (evt_count = FIFO_DEPTH):
  - Write with no read in the same cycle: event dropped, overflow set to 1, contents unchanged.
  - Write with a read in the same cycle: the write is accepted, evt_count stays FIFO_DEPTH, overflow is unchanged.
- Empty with write: entry stored; evt_valid rises next cycle. A same-cycle evt_ready has no effect because evt_valid was 0.
- overflow clearing:
  - ovf_clr=1 clears overflow on the next edge.
  - If a drop occurs in the same cycle as ovf_clr, the set wins and overflow = 1.
- Reset mid-operation: all queued events are discarded immediately and outputs return to their reset values. The first write after rst deasserts lands at address 0.
- Because the scanner emits at most one key_flag per debounced press, back-to-back key_flag strobes must still each be accepted. The block sustains one write per cycle.

Test Plan:
- Reset then single event: key_flag=1, key_value=4'b0100 for 1 cycle -> next cycle evt_valid=1, evt_mask=0100, evt_idx=2, evt_multi=0, evt_count=1. Pulse evt_ready -> evt_valid=0, evt_count=0.
- Zero and multi-key: key_flag with key_value=0000 -> evt_count stays 0. Then key_value=1010 -> evt_idx=1, evt_multi=1.
- Fill and overflow: 8 events with masks 0001,0010,0100,1000,0001,0010,0100,1000 and evt_ready=0 -> evt_count=8. A 9th event (0011) -> dropped, overflow=1, evt_count=8. Drain -> masks appear in original order. ovf_clr -> overflow=0.
- Full with simultaneous read and write: with the FIFO full, key_flag (mask 1100) and evt_ready in the same cycle -> head popped, 1100 queued at the tail, evt_count=8, overflow unchanged.
- Pointer wrap: 20 events with evt_ready held at 1 -> every event observed once, in order, evt_count never exceeds 1.
- Reset mid-operation: 3 events queued, then rst pulsed for 1 cycle -> evt_valid=0, evt_count=0. A new event 0001 -> evt_mask=0001 is the head.
